// File: rtl/barrel_shifter_pipe_pkg.sv
// rtl/barrel_shifter_pipe_pkg.sv - shared encodings and default sizes for the barrel shifter pipeline
package barrel_shifter_pipe_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_IMM_W = 8;
    localparam int DEF_ROT_W = 4;

    typedef enum logic [1:0] {
        MODE_ROT_IMM   = 2'd0,
        MODE_IMM_SHIFT = 2'd1,
        MODE_REG_SHIFT = 2'd2,
        MODE_RSVD      = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_type_e;

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// rtl/barrel_shifter_pipe_if.sv - request/response handshake bundle for the barrel shifter pipeline
interface barrel_shifter_pipe_if
    import barrel_shifter_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IMM_W = DEF_IMM_W,
    parameter int ROT_W = DEF_ROT_W
);
    localparam int SHIFT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [1:0]         mode;
    logic [1:0]         shift_type;
    logic [IMM_W-1:0]   immediate;
    logic [ROT_W-1:0]   rotate_imm;
    logic [WIDTH-1:0]   Rm;
    logic [SHIFT_W-1:0] shift_imm;
    logic [7:0]         Rs;
    logic               carryFlag;
    logic [WIDTH-1:0]   Y;
    logic               carry;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_valid, mode, shift_type, immediate, rotate_imm, Rm, shift_imm, Rs, carryFlag,
        output out_ready,
        input  in_ready, Y, carry, out_valid
    );

    modport slave (
        input  in_valid, mode, shift_type, immediate, rotate_imm, Rm, shift_imm, Rs, carryFlag,
        input  out_ready,
        output in_ready, Y, carry, out_valid
    );

endinterface

// File: rtl/shift_core.sv
// rtl/shift_core.sv - combinational shift/rotate with carry-out for a decoded amount and type
module shift_core
    import barrel_shifter_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = 8
) (
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amount,
    input  shift_type_e      shift_type,
    input  logic             carry_in,
    input  logic             rrx,
    output logic [WIDTH-1:0] y,
    output logic             carry
);
    localparam int LOG_W = $clog2(WIDTH);
    localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);

    logic [LOG_W-1:0] lo;
    logic [LOG_W-1:0] lo_m1;
    logic [LOG_W-1:0] neg_lo;
    logic [LOG_W:0]   ror_back;
    logic [WIDTH-1:0] ror_y;

    // Low bits double as the rotate amount (amount mod WIDTH) and, below WIDTH, the shift amount.
    assign lo       = amount[LOG_W-1:0];
    assign lo_m1    = lo - LOG_W'(1);
    assign neg_lo   = ~lo + LOG_W'(1);
    assign ror_back = (LOG_W+1)'(WIDTH) - {1'b0, lo};
    assign ror_y    = (operand >> lo) | (operand << ror_back);

    always_comb begin
        y     = operand;
        carry = carry_in;
        if (rrx) begin
            y     = {carry_in, operand[WIDTH-1:1]};
            carry = operand[0];
        end else if (amount != '0) begin
            case (shift_type)
                SH_LSL: begin
                    if (amount < W_AMT) begin
                        y     = operand << lo;
                        carry = operand[neg_lo];
                    end else begin
                        y     = '0;
                        carry = (amount == W_AMT) ? operand[0] : 1'b0;
                    end
                end
                SH_LSR: begin
                    if (amount < W_AMT) begin
                        y     = operand >> lo;
                        carry = operand[lo_m1];
                    end else begin
                        y     = '0;
                        carry = (amount == W_AMT) ? operand[WIDTH-1] : 1'b0;
                    end
                end
                SH_ASR: begin
                    if (amount < W_AMT) begin
                        y     = WIDTH'($signed(operand) >>> lo);
                        carry = operand[lo_m1];
                    end else begin
                        y     = {WIDTH{operand[WIDTH-1]}};
                        carry = operand[WIDTH-1];
                    end
                end
                default: begin
                    y     = ror_y;
                    carry = ror_y[WIDTH-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// rtl/barrel_shifter_pipe.sv - two-stage shifter-operand pipeline; BARREL_SHIFTER_RRX_EN enables RRX on ROR #0
module barrel_shifter_pipe
    import barrel_shifter_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IMM_W = DEF_IMM_W,
    parameter int ROT_W = DEF_ROT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    barrel_shifter_pipe_if.slave bus
);
    localparam int LOG_W = $clog2(WIDTH);
    localparam int AMT_W = (LOG_W + 1 > 8) ? LOG_W + 1 : 8;
    localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);

    logic [WIDTH-1:0] dec_operand;
    logic [AMT_W-1:0] dec_amount;
    shift_type_e      dec_type;
    logic             dec_rrx;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_operand;
    logic [AMT_W-1:0] s1_amount;
    shift_type_e      s1_type;
    logic             s1_carry;
    logic             s1_rrx;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_y;
    logic             s2_carry;

    logic             s1_adv;
    logic             in_ready;
    logic [WIDTH-1:0] core_y;
    logic             core_carry;

    assign s1_adv   = !s2_valid || bus.out_ready;
    assign in_ready = !reset && (!s1_valid || s1_adv);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.Y         = s2_y;
    assign bus.carry     = s2_carry;

    // Every mode collapses to (operand, amount, type); the reserved mode becomes a zero operand, no shift.
    always_comb begin
        dec_operand = bus.Rm;
        dec_amount  = '0;
        dec_type    = shift_type_e'(bus.shift_type);
        dec_rrx     = 1'b0;
        case (mode_e'(bus.mode))
            MODE_ROT_IMM: begin
                dec_operand = WIDTH'(bus.immediate);
                dec_amount  = AMT_W'({bus.rotate_imm, 1'b0});
                dec_type    = SH_ROR;
            end
            MODE_IMM_SHIFT: begin
                dec_amount = AMT_W'(bus.shift_imm);
                if (bus.shift_imm == '0) begin
                    if (dec_type == SH_LSR || dec_type == SH_ASR) begin
                        dec_amount = W_AMT;
                    end else if (dec_type == SH_ROR) begin
`ifdef BARREL_SHIFTER_RRX_EN
                        dec_rrx = 1'b1;
`else
                        dec_rrx = 1'b0;
`endif
                    end
                end
            end
            MODE_REG_SHIFT: begin
                dec_amount = AMT_W'(bus.Rs);
            end
            default: begin
                dec_operand = '0;
                dec_type    = SH_LSL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_operand <= '0;
            s1_amount  <= '0;
            s1_type    <= SH_LSL;
            s1_carry   <= 1'b0;
            s1_rrx     <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (bus.in_valid && in_ready) begin
                s1_operand <= dec_operand;
                s1_amount  <= dec_amount;
                s1_type    <= dec_type;
                s1_carry   <= bus.carryFlag;
                s1_rrx     <= dec_rrx;
            end
        end
    end

    shift_core #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_shift_core (
        .operand    (s1_operand),
        .amount     (s1_amount),
        .shift_type (s1_type),
        .carry_in   (s1_carry),
        .rrx        (s1_rrx),
        .y          (core_y),
        .carry      (core_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_y     <= '0;
            s2_carry <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_y     <= core_y;
                s2_carry <= core_carry;
            end
        end
    end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb/tb_barrel_shifter_pipe.sv - scoreboard bench for barrel_shifter_pipe against an arithmetic reference model
module tb_barrel_shifter_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    barrel_shifter_pipe_if bus ();

    barrel_shifter_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [32:0] exp_q[$];
    logic [32:0] cur_exp;
    bit          stall    = 1'b0;
    bit          rand_rdy = 1'b0;
    bit          held     = 1'b0;
    logic [32:0] held_val;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] v, input int k);
        logic [63:0] d;
        d = {v, v} >> k;
        return d[31:0];
    endfunction

    function automatic logic [32:0] shift_by(input logic [1:0] st, input logic [31:0] rm, input int n);
        logic [63:0] v;
        longint      t;
        logic [31:0] y;
        case (st)
            2'd0: begin
                if (n > 32) return 33'h0;
                v = {32'h0, rm} << n;
                return {v[32], v[31:0]};
            end
            2'd1: begin
                if (n > 32) return 33'h0;
                v = {rm, 32'h0} >> n;
                return {v[31], v[63:32]};
            end
            2'd2: begin
                t = $signed({rm, 32'h0});
                t = t >>> ((n > 32) ? 32 : n);
                return {t[31], t[63:32]};
            end
            default: begin
                y = ror32(rm, n % 32);
                return {y[31], y};
            end
        endcase
    endfunction

    function automatic logic [32:0] model(input logic [1:0] mode, input logic [1:0] st,
                                          input logic [7:0] imm, input logic [3:0] rot,
                                          input logic [31:0] rm, input logic [4:0] shimm,
                                          input logic [7:0] rs, input logic cf);
        logic [31:0] y;
        case (mode)
            2'd0: begin
                y = ror32({24'h0, imm}, (2 * rot) % 32);
                return {(rot == 0) ? cf : y[31], y};
            end
            2'd1: begin
                if (shimm == 0) begin
                    case (st)
                        2'd0: return {cf, rm};
                        2'd3: begin
`ifdef BARREL_SHIFTER_RRX_EN
                            return {rm[0], cf, rm[31:1]};
`else
                            return {cf, rm};
`endif
                        end
                        default: return shift_by(st, rm, 32);
                    endcase
                end
                return shift_by(st, rm, int'(shimm));
            end
            2'd2: begin
                if (rs == 0) return {cf, rm};
                return shift_by(st, rm, int'(rs));
            end
            default: return {cf, 32'h0};
        endcase
    endfunction

    task automatic drive(input logic [1:0] mode, input logic [1:0] st, input logic [7:0] imm,
                         input logic [3:0] rot, input logic [31:0] rm, input logic [4:0] shimm,
                         input logic [7:0] rs, input logic cf, input logic [32:0] exp_val);
        bus.mode       = mode;
        bus.shift_type = st;
        bus.immediate  = imm;
        bus.rotate_imm = rot;
        bus.Rm         = rm;
        bus.shift_imm  = shimm;
        bus.Rs         = rs;
        bus.carryFlag  = cf;
        bus.in_valid   = 1'b1;
        cur_exp        = exp_val;
    endtask

    // Returns on the falling edge just before the accepting rising edge.
    task automatic wait_accept();
        int budget = 200;
        while (!bus.in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept_within_200");
            bus.in_valid = 1'b0;
        end else begin
            exp_q.push_back(cur_exp);
        end
    endtask

    task automatic send(input logic [1:0] mode, input logic [1:0] st, input logic [7:0] imm,
                        input logic [3:0] rot, input logic [31:0] rm, input logic [4:0] shimm,
                        input logic [7:0] rs, input logic cf, input logic [32:0] exp_val);
        @(negedge clk);
        drive(mode, st, imm, rot, rm, shimm, rs, cf, exp_val);
        wait_accept();
    endtask

    task automatic send_rand();
        logic [1:0]  mode, st;
        logic [7:0]  imm, rs;
        logic [3:0]  rot;
        logic [31:0] rm;
        logic [4:0]  shimm;
        logic        cf;
        logic [7:0]  rs_tab[8];
        rs_tab = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd64, 8'd255, 8'd0};
        mode  = 2'($urandom_range(3));
        st    = 2'($urandom_range(3));
        imm   = 8'($urandom);
        rot   = 4'($urandom);
        rm    = $urandom;
        shimm = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
        rs    = rs_tab[$urandom_range(7)];
        if ($urandom_range(7) == 7) rs = 8'($urandom);
        cf    = 1'($urandom);
        send(mode, st, imm, rot, rm, shimm, rs, cf, model(mode, st, imm, rot, rm, shimm, rs, cf));
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = stall ? 1'b0 : (rand_rdy ? ($urandom_range(3) != 0) : 1'b1);
        end
    end

    // Monitor: pops on every handshake and checks stability across stalled cycles.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", 64'(bus.out_valid), 64'd1);
                    check("hold_data", 64'({bus.carry, bus.Y}), 64'(held_val));
                end
                held = 1'b0;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output actual=%0h required=no_output", {bus.carry, bus.Y});
                    end else begin
                        e = exp_q.pop_front();
                        check("result", 64'({bus.carry, bus.Y}), 64'(e));
                    end
                end else if (bus.out_valid) begin
                    held     = 1'b1;
                    held_val = {bus.carry, bus.Y};
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.mode       = '0;
        bus.shift_type = '0;
        bus.immediate  = '0;
        bus.rotate_imm = '0;
        bus.Rm         = '0;
        bus.shift_imm  = '0;
        bus.Rs         = '0;
        bus.carryFlag  = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_y", 64'(bus.Y), 64'd0);
        check("rst_carry", 64'(bus.carry), 64'd0);

        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("first_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) @(negedge clk);

        send(2'd0, 2'd0, 8'hFF, 4'd4, 32'h0, 5'd0, 8'd0, 1'b0, {1'b1, 32'hFF000000});
        idle();
        check("latency_cycle1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("latency_cycle2", 64'(bus.out_valid), 64'd1);

        send(2'd0, 2'd0, 8'h12, 4'd0, 32'h0, 5'd0, 8'd0, 1'b1, {1'b1, 32'h00000012});
        send(2'd1, 2'd1, 8'h00, 4'd0, 32'h80000000, 5'd0, 8'd0, 1'b0, {1'b1, 32'h0});
        send(2'd2, 2'd2, 8'h00, 4'd0, 32'h80000001, 5'd0, 8'd40, 1'b0, {1'b1, 32'hFFFFFFFF});
`ifdef BARREL_SHIFTER_RRX_EN
        send(2'd1, 2'd3, 8'h00, 4'd0, 32'h00000003, 5'd0, 8'd0, 1'b1, {1'b1, 32'h80000001});
`else
        send(2'd1, 2'd3, 8'h00, 4'd0, 32'h00000003, 5'd0, 8'd0, 1'b1, {1'b1, 32'h00000003});
`endif
        send(2'd3, 2'd1, 8'h55, 4'd3, 32'hDEADBEEF, 5'd7, 8'd9, 1'b1, {1'b1, 32'h0});
        send(2'd2, 2'd0, 8'h00, 4'd0, 32'h00000001, 5'd0, 8'd32, 1'b0, {1'b1, 32'h0});
        send(2'd2, 2'd3, 8'h00, 4'd0, 32'h80000000, 5'd0, 8'd64, 1'b0, {1'b1, 32'h80000000});
        idle();
        repeat (4) @(negedge clk);

        // Three back-to-back requests into a stalled consumer.
        stall = 1'b1;
        @(posedge clk);
        send(2'd1, 2'd0, 8'h00, 4'd0, 32'h00000001, 5'd4, 8'd0, 1'b0, {1'b0, 32'h00000010});
        send(2'd1, 2'd1, 8'h00, 4'd0, 32'h00000100, 5'd8, 8'd0, 1'b0, {1'b0, 32'h00000001});
        @(negedge clk);
        drive(2'd1, 2'd2, 8'h00, 4'd0, 32'hF0000000, 5'd4, 8'd0, 1'b0, {1'b0, 32'hFF000000});
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (4) begin
            @(negedge clk);
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        end
        stall = 1'b0;
        wait_accept();
        idle();
        repeat (6) @(negedge clk);
        check("stall_drained", 64'(exp_q.size()), 64'd0);

        // Reset with two requests in flight.
        stall = 1'b1;
        @(posedge clk);
        send(2'd2, 2'd0, 8'h00, 4'd0, 32'h12345678, 5'd0, 8'd4, 1'b0, {1'b1, 32'h23456780});
        send(2'd2, 2'd1, 8'h00, 4'd0, 32'h12345678, 5'd0, 8'd4, 1'b0, {1'b1, 32'h01234567});
        idle();
        check("inflight_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        check("midrst_y", 64'(bus.Y), 64'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        stall = 1'b0;
        #1 check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (6) begin
            @(negedge clk);
            check("no_stale_output", 64'(bus.out_valid), 64'd0);
        end

        rand_rdy = 1'b1;
        repeat (400) send_rand();
        idle();
        budget = 2000;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("final_drain", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_pipe.md
BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 Parameter WIDTH, default 32: data path width; SHALL be a power of two, at least 8.
REQ-002 Parameter IMM_W, default 8: immediate field width.
REQ-003 Parameter ROT_W, default 4: rotate field width; rotate amount = 2*rotate_imm.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  request present.
REQ-008 in_ready  out  1  request accepted when in_valid && in_ready.
REQ-009 mode  in  2  0=rotated immediate, 1=immediate-amount shift, 2=register-amount shift, 3=reserved.
REQ-010 shift_type  in  2  0=LSL, 1=LSR, 2=ASR, 3=ROR.
REQ-011 immediate  in  IMM_W  immediate operand (mode 0).
REQ-012 rotate_imm  in  ROT_W  rotate field (mode 0).
REQ-013 Rm  in  WIDTH  register operand (modes 1, 2).
REQ-014 shift_imm  in  log2(WIDTH)  shift amount (mode 1).
REQ-015 Rs  in  8  low byte of shift register (mode 2).
REQ-016 carryFlag  in  1  current C flag, sampled with the request.
REQ-017 Y  out  WIDTH  shifter operand result.
REQ-018 carry  out  1  shifter carry-out.
REQ-019 out_valid  out  1  Y/carry valid.
REQ-020 out_ready  in  1  consumer accepts when out_valid && out_ready.

Function
REQ-021 Two-stage pipeline: stage 1 registers the decoded amount, type, operand and carryFlag; stage 2 registers Y/carry; latency exactly 2 cycles with no backpressure.
REQ-022 Full throughput: one request accepted per cycle while out_ready=1.
REQ-023 in_ready = !s1_valid || s1 advancing; s1 advances when !s2_valid || out_ready.
REQ-024 While out_valid && !out_ready, Y, carry and out_valid SHALL hold stable; no request is lost, duplicated or reordered.
REQ-025 Mode 0: Y = zero-extended immediate rotated right by 2*rotate_imm; carry = carryFlag if rotate_imm==0, else Y[WIDTH-1].
REQ-026 Mode 1 LSL #0: Y=Rm, carry=carryFlag; LSL #n: carry = Rm[WIDTH-n].
REQ-027 Mode 1 LSR #0 or ASR #0 encodes a shift of WIDTH: LSR gives Y=0, carry=Rm[WIDTH-1]; ASR gives Y = all copies of Rm[WIDTH-1], carry=Rm[WIDTH-1].
REQ-028 Mode 1 ROR #0: RRX when enabled (see Configuration).
REQ-029 Mode 2 amount = Rs[7:0]; amount 0: Y=Rm, carry=carryFlag for all types.
REQ-030 Mode 2 LSL/LSR amount == WIDTH: Y=0, carry = Rm[0] (LSL) or Rm[WIDTH-1] (LSR); amount > WIDTH: Y=0, carry=0.
REQ-031 Mode 2 ASR amount >= WIDTH: Y and carry = Rm[WIDTH-1] replicated.
REQ-032 Mode 2 ROR: effective amount = Rs mod WIDTH; if that is 0 and Rs != 0, Y=Rm, carry=Rm[WIDTH-1].
REQ-033 Mode 3 request is accepted and produces Y=0, carry=carryFlag.

Reset
REQ-034 While reset=1: Y=0, carry=0, out_valid=0, in_ready=0; all pipeline valids are cleared.
REQ-035 The first cycle after reset deasserts: in_ready=1.
REQ-036 Reset mid-operation discards in-flight requests; no out_valid appears for them.

Configuration
REQ-037 Macro BARREL_SHIFTER_RRX_EN defined: mode 1 ROR #0 gives Y = {carryFlag, Rm[WIDTH-1:1]}, carry=Rm[0].
REQ-038 Macro undefined: mode 1 ROR #0 gives Y=Rm, carry=carryFlag.

Structure
REQ-039 Shared package holds the mode and shift_type encodings, and the default WIDTH/IMM_W/ROT_W constants.
REQ-040 One sub-module, shift_core: combinational shift/rotate plus carry for a given amount and type; instantiated between stage 1 and stage 2.

Verification
REQ-041 Mode 0, immediate=0xFF, rotate_imm=4 -> Y=0xFF000000, carry=1, two cycles after acceptance.
REQ-042 Mode 0, immediate=0x12, rotate_imm=0, carryFlag=1 -> Y=0x00000012, carry=1.
REQ-043 Mode 1 LSR #0, Rm=0x80000000 -> Y=0, carry=1; Mode 2 ASR, Rs=40, Rm=0x80000001 -> Y=0xFFFFFFFF, carry=1.
REQ-044 Mode 1 ROR #0, Rm=0x00000003, carryFlag=1 -> with macro: Y=0x80000001, carry=1; without macro: Y=0x00000003, carry=1.
REQ-045 Three back-to-back requests with out_ready=0 for 5 cycles -> in_ready drops after 2 are accepted; outputs hold; all 3 results delivered in order after release.
REQ-046 Reset asserted with 2 requests in flight -> out_valid=0 immediately; no stale result after reset deasserts.
